// File: rtl/cdb_arbiter_pkg.sv
// -----------------------------------------------------------------------------
// cdb_arbiter_pkg
//   Shared constants for the common-data-bus arbiter slice.
//   - TAG_FREE / DATA_FREE : idle values driven on the CDB when nothing is
//                            broadcast. TAG_FREE is never a legal producer tag.
//   - ENABLE / DISABLE     : broadcast-valid encodings.
//   - producer_e           : fixed producer slot assignment.
//   - ptr_width / wrap_add : helpers for the round-robin pointer arithmetic.
// -----------------------------------------------------------------------------
package cdb_arbiter_pkg;

    localparam int TAG_BUS_W  = 4;
    localparam int DATA_BUS_W = 32;

    localparam logic [TAG_BUS_W-1:0]  TAG_FREE  = '0;
    localparam logic [DATA_BUS_W-1:0] DATA_FREE = '0;

    localparam logic ENABLE  = 1'b1;
    localparam logic DISABLE = 1'b0;

    typedef enum int {
        PROD_ALU = 0,
        PROD_LS  = 1,
        PROD_BR  = 2
    } producer_e;

    // Width of a binary index into n entries; a single entry still gets one bit.
    function automatic int ptr_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    // (a + b) mod n for 0 <= a < n, 0 <= b < n.
    function automatic int wrap_add(input int a, input int b, input int n);
        int s;
        s = a + b;
        if (s >= n) begin
            s = s - n;
        end
        return s;
    endfunction

endpackage

// File: rtl/cdb_arbiter_rr_pick.sv
// -----------------------------------------------------------------------------
// cdb_arbiter_rr_pick
//   Combinational round-robin picker. Scans cand starting at ptr and wrapping
//   modulo N; the first set bit wins.
//   Ports:
//     cand  in  N      candidate vector
//     ptr   in  PTR_W  scan start position (0..N-1)
//     grant out N      one-hot grant (all zero when no candidate)
//     valid out 1      at least one candidate present
//     idx   out PTR_W  binary index of the granted candidate (0 when !valid)
// -----------------------------------------------------------------------------
module cdb_arbiter_rr_pick
    import cdb_arbiter_pkg::*;
#(
    parameter int N     = 3,
    parameter int PTR_W = ptr_width(N)
) (
    input  logic [N-1:0]     cand,
    input  logic [PTR_W-1:0] ptr,
    output logic [N-1:0]     grant,
    output logic             valid,
    output logic [PTR_W-1:0] idx
);

    always_comb begin
        grant = '0;
        valid = 1'b0;
        idx   = '0;
        for (int k = 0; k < N; k++) begin
            if (!valid && cand[wrap_add(int'(ptr), k, N)]) begin
                valid = 1'b1;
                grant[wrap_add(int'(ptr), k, N)] = 1'b1;
                idx   = PTR_W'(wrap_add(int'(ptr), k, N));
            end
        end
    end

endmodule

// File: rtl/cdb_arbiter.sv
// -----------------------------------------------------------------------------
// cdb_arbiter
//   Shares the single registered common data bus among N_REQ result producers
//   (0 = ALU, 1 = LS, 2 = branch link writeback). Every producer owns a
//   one-entry holding slot so a result that loses arbitration is still accepted
//   and parked; a round-robin picker selects one candidate per cycle.
//
//   Ports:
//     clk, rst   clock / asynchronous active-high reset
//     rdy        global ready; low freezes every register
//     flush      mispredict flush: drops parked and live results, ptr -> 0
//     req_valid  per-producer result present
//     req_tag    packed tags, producer i at [i*TAG_W +: TAG_W]
//     req_data   packed results, producer i at [i*DATA_W +: DATA_W]
//     req_ready  result from producer i is accepted at this edge
//     cdb_en     registered broadcast valid
//     cdb_tag    registered broadcast tag (TAG_FREE when idle)
//     cdb_data   registered broadcast data (DATA_FREE when idle)
// -----------------------------------------------------------------------------
module cdb_arbiter
    import cdb_arbiter_pkg::*;
#(
    parameter int N_REQ  = 3,
    parameter int DATA_W = 32,
    parameter int TAG_W  = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    rdy,
    input  logic                    flush,
    input  logic [N_REQ-1:0]        req_valid,
    input  logic [N_REQ*TAG_W-1:0]  req_tag,
    input  logic [N_REQ*DATA_W-1:0] req_data,
    output logic [N_REQ-1:0]        req_ready,
    output logic                    cdb_en,
    output logic [TAG_W-1:0]        cdb_tag,
    output logic [DATA_W-1:0]       cdb_data
);

    localparam int PTR_W = ptr_width(N_REQ);

    localparam logic [TAG_W-1:0]  IDLE_TAG  = TAG_W'(TAG_FREE);
    localparam logic [DATA_W-1:0] IDLE_DATA = DATA_W'(DATA_FREE);
    localparam logic [PTR_W-1:0]  PTR_LAST  = PTR_W'(N_REQ - 1);

    // ---------------------------------------------------------------- state
    logic [N_REQ-1:0]  slot_v_q,    slot_v_d;
    logic [TAG_W-1:0]  slot_tag_q   [N_REQ];
    logic [TAG_W-1:0]  slot_tag_d   [N_REQ];
    logic [DATA_W-1:0] slot_data_q  [N_REQ];
    logic [DATA_W-1:0] slot_data_d  [N_REQ];
    logic [PTR_W-1:0]  ptr_q,       ptr_d;
    logic              cdb_en_q,    cdb_en_d;
    logic [TAG_W-1:0]  cdb_tag_q,   cdb_tag_d;
    logic [DATA_W-1:0] cdb_data_q,  cdb_data_d;

    // ---------------------------------------------------------- candidates
    logic [N_REQ-1:0]  cand;
    logic [TAG_W-1:0]  cand_tag  [N_REQ];
    logic [DATA_W-1:0] cand_data [N_REQ];
    logic [N_REQ-1:0]  grant;
    logic              pick_valid;
    logic [PTR_W-1:0]  pick_idx;
    logic [TAG_W-1:0]  win_tag;
    logic [DATA_W-1:0] win_data;
    logic              accept;

    // A parked result always has priority over the live request of the same
    // producer, so results from one producer leave in arrival order.
    always_comb begin
        cand = slot_v_q | req_valid;
        for (int i = 0; i < N_REQ; i++) begin
            cand_tag[i]  = slot_v_q[i] ? slot_tag_q[i]  : req_tag[i*TAG_W +: TAG_W];
            cand_data[i] = slot_v_q[i] ? slot_data_q[i] : req_data[i*DATA_W +: DATA_W];
        end
    end

    cdb_arbiter_rr_pick #(
        .N     (N_REQ),
        .PTR_W (PTR_W)
    ) u_rr_pick (
        .cand  (cand),
        .ptr   (ptr_q),
        .grant (grant),
        .valid (pick_valid),
        .idx   (pick_idx)
    );

    // Grant is one-hot, so an AND-OR mux selects the winning payload.
    always_comb begin
        win_tag  = '0;
        win_data = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (grant[i]) begin
                win_tag  = win_tag  | cand_tag[i];
                win_data = win_data | cand_data[i];
            end
        end
    end

    // A producer may hand over a result when its slot is free, or when the
    // parked result is leaving on the bus this cycle (slot is refilled).
    assign accept    = rdy & ~flush;
    assign req_ready = accept ? (~slot_v_q | grant) : '0;

    // ---------------------------------------------------------- next state
    always_comb begin
        slot_v_d    = slot_v_q;
        slot_tag_d  = slot_tag_q;
        slot_data_d = slot_data_q;
        ptr_d       = ptr_q;
        cdb_en_d    = cdb_en_q;
        cdb_tag_d   = cdb_tag_q;
        cdb_data_d  = cdb_data_q;

        if (rdy) begin
            if (flush) begin
                // Everything in flight belongs to the squashed path.
                slot_v_d   = '0;
                ptr_d      = '0;
                cdb_en_d   = DISABLE;
                cdb_tag_d  = IDLE_TAG;
                cdb_data_d = IDLE_DATA;
            end else begin
                for (int i = 0; i < N_REQ; i++) begin
                    if (grant[i]) begin
                        // Winner leaves; a slot winner is refilled by a live
                        // request, a live winner never touches the slot.
                        slot_v_d[i] = slot_v_q[i] & req_valid[i];
                        if (slot_v_q[i] && req_valid[i]) begin
                            slot_tag_d[i]  = req_tag[i*TAG_W +: TAG_W];
                            slot_data_d[i] = req_data[i*DATA_W +: DATA_W];
                        end
                    end else if (!slot_v_q[i] && req_valid[i]) begin
                        slot_v_d[i]    = 1'b1;
                        slot_tag_d[i]  = req_tag[i*TAG_W +: TAG_W];
                        slot_data_d[i] = req_data[i*DATA_W +: DATA_W];
                    end
                end

                if (pick_valid) begin
                    cdb_en_d   = ENABLE;
                    cdb_tag_d  = win_tag;
                    cdb_data_d = win_data;
                    ptr_d      = (pick_idx == PTR_LAST) ? '0 : pick_idx + PTR_W'(1);
                end else begin
                    cdb_en_d   = DISABLE;
                    cdb_tag_d  = IDLE_TAG;
                    cdb_data_d = IDLE_DATA;
                end
            end
        end
    end

    // ------------------------------------------------------------ registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            slot_v_q   <= '0;
            ptr_q      <= '0;
            cdb_en_q   <= DISABLE;
            cdb_tag_q  <= IDLE_TAG;
            cdb_data_q <= IDLE_DATA;
        end else begin
            slot_v_q   <= slot_v_d;
            ptr_q      <= ptr_d;
            cdb_en_q   <= cdb_en_d;
            cdb_tag_q  <= cdb_tag_d;
            cdb_data_q <= cdb_data_d;
        end
    end

    // Slot payloads are qualified by slot_v_q and need no reset.
    always_ff @(posedge clk) begin
        slot_tag_q  <= slot_tag_d;
        slot_data_q <= slot_data_d;
    end

    assign cdb_en   = cdb_en_q;
    assign cdb_tag  = cdb_tag_q;
    assign cdb_data = cdb_data_q;

endmodule
